hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. Consumes the Decode- and Execute-stage register identifiers and control bits, and tracks Memory/Writeback destinations in internal shadow registers. From these it generates the stall, flush and forwarding controls for the F/D, D/E and E/M pipeline registers, including the `flushE` input of the D→E register. It also freezes the pipeline during data-memory wait states and keeps saturating stall/flush statistics.

## Interface
- `WIDTH`, 32, datapath width; sizes nothing internally and is kept for consistency.
- `MAX_WAIT`, 15, number of consecutive memory-wait cycles before `mem_timeout` sets; valid range 1..255.
- `CNT_W`, 16, width of the performance counters.

- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `rs1D`, `rs2D` in 5: source registers of the instruction in Decode.
- `rs1E`, `rs2E`, `rdE` in 5: source and destination registers in Execute.
- `regwriteE` in 1: the instruction in Execute writes the register file.
- `resultsrcE` in 2: result select in Execute; `2'b01` marks a load.
- `pcsrcE` in 2: PC select in Execute; any nonzero value is a taken redirect.
- `mem_req` in 1: the instruction in Memory accesses data memory.
- `mem_ready` in 1: data memory completes the access this cycle.
- `stallF`, `stallD`, `stallE`, `stallM` out 1: hold the PC, F/D, D/E and E/M registers respectively.
- `flushD`, `flushE` out 1: clear the F/D and D/E registers respectively.
- `forwardAE`, `forwardBE` out 2: ALU operand select.
  - `00`: register file.
  - `10`: Memory-stage result.
  - `01`: Writeback result.
- `mem_busy` out 1: the FSM is in WAIT.
- `mem_timeout` out 1: sticky error flag.
- `stall_cnt`, `flush_cnt` out `CNT_W`: saturating counters.

## Operation
- **Shadow pipeline** (`rdM`, `regwriteM`, `rdW`, `regwriteW`):
  - On each posedge where `mem_stall` = 0: `rdM`<=`rdE`, `regwriteM`<=`regwriteE`, `rdW`<=`rdM`, `regwriteW`<=`regwriteM`.
  - While `mem_stall` = 1: all four hold their values.
- **Forwarding** (combinational), shown for A; B is identical using `rs2E`:
  - If `regwriteM` && `rdM`≠0 && `rdM`==`rs1E`, then `10`.
  - Else if `regwriteW` && `rdW`≠0 && `rdW`==`rs1E`, then `01`.
  - Else `00`.
  - Memory-stage forwarding takes priority over Writeback.
- **Hazard terms:**
  - `mem_stall` = `mem_req` && !`mem_ready`.
  - `lduse` = `resultsrcE`==01 && `rdE`≠0 && (`rdE`==`rs1D` || `rdE`==`rs2D`).
  - `redirect` = `pcsrcE`≠0.
- **Priority, highest first:**
  1. `mem_stall`: all four stalls = 1, both flushes = 0.
  2. `redirect`: `flushD` = `flushE` = 1, all stalls = 0. A redirect overrides a load-use hazard because the dependent instruction is squashed.
  3. `lduse`: `stallF` = `stallD` = 1, `flushE` = 1, others 0.
  4. Otherwise all outputs are 0.
- **Memory FSM**, states RUN and WAIT, with an 8-bit `wait_cnt`:
  - RUN → WAIT when `mem_stall`; `wait_cnt`<=1.
  - WAIT stays in WAIT while `mem_stall`; `wait_cnt` increments and saturates at 255.
  - WAIT → RUN when `mem_ready` or !`mem_req`; `wait_cnt`<=0.
  - `mem_busy` = (state==WAIT).
  - `mem_timeout` sets when `wait_cnt`==`MAX_WAIT` in WAIT and holds until reset.
- **Counters:**
  - `stall_cnt` increments in each cycle where `stallF`=1.
  - `flush_cnt` increments in each cycle where `flushE`=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and the registered shadow/FSM state, valid in the same cycle. There is no added latency.
- A load-use hazard produces exactly one bubble: the stall lasts one cycle because the load has moved to Memory on the next edge.
- Forwarding of an Execute result reaches the next instruction one cycle later via `rdM` (`10`), and two cycles later via `rdW` (`01`).
- Reset (`rst_n`=0 at a posedge) clears:
  - `rdM`, `rdW`, `regwriteM`, `regwriteW`;
  - the FSM state (to RUN) and `wait_cnt`;
  - `mem_timeout`, `stall_cnt` and `flush_cnt`.
- Reset asserted during a memory wait returns the FSM to RUN on that edge.
- Combinational outputs still follow the inputs during reset, but forwarding reads the shadow registers, which are zero after that edge.
- `mem_ready` arriving in the same cycle as `mem_req` causes no stall and leaves the FSM in RUN.
- A register index of 0 never forwards and never causes a load-use stall.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with all inputs 0 → all outputs 0, `mem_busy`=0, both counters 0.
- **Load-use:** `resultsrcE`=01, `rdE`=5, `rs1D`=5 → `stallF`=`stallD`=`flushE`=1 for one cycle, and `flush_cnt`=1.
  - Repeat with `rdE`=0 → no stall.
- **Forwarding:** cycle 0 `regwriteE`=1, `rdE`=7; cycle 1 `rs1E`=7 → `forwardAE`=10.
  - Cycle 2 with `rs1E`=7 → `01`.
  - Same `rd` in both M and W → `10` wins.
- **Redirect during load-use:** `pcsrcE`=01 together with the load-use conditions → `flushD`=`flushE`=1, `stallF`=`stallD`=0.
- **Memory wait:** `mem_req`=1, `mem_ready`=0 for 3 cycles, then `mem_ready`=1 →
  - all stalls = 1 for 3 cycles;
  - `mem_busy` = 1 from the cycle after the wait begins;
  - the shadow registers hold;
  - the FSM returns to RUN after `mem_ready`.
- **Timeout:** with `MAX_WAIT`=4, hold `mem_stall` for 6 cycles → `mem_timeout` rises on the 5th edge.
  - It stays high after `mem_ready` and clears only on `rst_n`=0.
  - Separately, force `stall_cnt` to saturate at 0xFFFF and hold there.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the 5-stage RV32I pipeline,
// with a data-memory wait FSM, a sticky wait-timeout flag and saturating
// stall/flush statistics counters.
module hazard_ctrl #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic             regwriteE,
    input  logic [1:0]       resultsrcE,
    input  logic [1:0]       pcsrcE,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             mem_busy,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W   = 8;
    localparam logic [1:0]  RES_LOAD = 2'b01;
    localparam logic [1:0]  FWD_RF   = 2'b00;
    localparam logic [1:0]  FWD_MEM  = 2'b10;
    localparam logic [1:0]  FWD_WB   = 2'b01;

    // Reject parameter values the timeout comparator cannot represent.
    if (WIDTH < 1 || MAX_WAIT < 1 || MAX_WAIT > 255 || CNT_W < 1) begin : g_param_check
        $error("hazard_ctrl: illegal parameter value");
    end

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // Shadow copies of the Memory and Writeback destination fields.
    logic [4:0]        rdM_q;
    logic              regwriteM_q;
    logic [4:0]        rdW_q;
    logic              regwriteW_q;

    mem_state_e        state_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              mem_busy_q;
    logic              mem_timeout_q;

    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_d;

    logic              mem_stall;
    logic              lduse;
    logic              redirect;

    // Raw hazard conditions from the current Decode/Execute/Memory inputs.
    always_comb begin
        mem_stall = mem_req && !mem_ready;
        redirect  = (pcsrcE != 2'b00);
        lduse     = (resultsrcE == RES_LOAD) && (rdE != 5'd0) &&
                    ((rdE == rs1D) || (rdE == rs2D));
    end

    // Prioritised stall/flush controls: memory wait, then redirect, then load-use.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (mem_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else if (redirect) begin
            // The load-use dependent is squashed, so no bubble is needed.
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (lduse) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    // ALU operand bypass; the younger Memory-stage result wins over Writeback.
    always_comb begin
        forwardAE = FWD_RF;
        forwardBE = FWD_RF;
        if (regwriteM_q && (rdM_q != 5'd0) && (rdM_q == rs1E)) begin
            forwardAE = FWD_MEM;
        end else if (regwriteW_q && (rdW_q != 5'd0) && (rdW_q == rs1E)) begin
            forwardAE = FWD_WB;
        end
        if (regwriteM_q && (rdM_q != 5'd0) && (rdM_q == rs2E)) begin
            forwardBE = FWD_MEM;
        end else if (regwriteW_q && (rdW_q != 5'd0) && (rdW_q == rs2E)) begin
            forwardBE = FWD_WB;
        end
    end

    // Advance the destination shadow pipeline unless memory is stalling it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdM_q       <= 5'd0;
            regwriteM_q <= 1'b0;
            rdW_q       <= 5'd0;
            regwriteW_q <= 1'b0;
        end else if (!mem_stall) begin
            rdM_q       <= rdE;
            regwriteM_q <= regwriteE;
            rdW_q       <= rdM_q;
            regwriteW_q <= regwriteM_q;
        end
    end

    // Memory wait FSM with saturating wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_busy_q    <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            if ((state_q == WAIT) && (wait_cnt_q == WAIT_W'(MAX_WAIT))) begin
                mem_timeout_q <= 1'b1;
            end
            case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= WAIT_W'(1);
                        mem_busy_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_stall) begin
                        if (wait_cnt_q != {WAIT_W{1'b1}}) begin
                            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                        end
                    end else begin
                        state_q    <= RUN;
                        wait_cnt_q <= '0;
                        mem_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    wait_cnt_q <= '0;
                    mem_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Next values of the saturating statistics counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flushE && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_busy    = mem_busy_q;
    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus randomized stimulus, expected responses queued
// by a behavioural model and checked by an independent monitor each cycle.
module tb_hazard_ctrl;

    localparam int unsigned MAXW = 4;
    localparam int unsigned CW   = 16;
    localparam int unsigned SW   = 4;
    localparam int          SAT_BIG   = 65535;
    localparam int          SAT_SMALL = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE;
    logic       regwriteE;
    logic [1:0] resultsrcE, pcsrcE;
    logic       mem_req, mem_ready;

    logic          stallF, stallD, stallE, stallM, flushD, flushE;
    logic [1:0]    forwardAE, forwardBE;
    logic          mem_busy, mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    logic          s_stallF, s_stallD, s_stallE, s_stallM, s_flushD, s_flushE;
    logic [1:0]    s_forwardAE, s_forwardBE;
    logic          s_mem_busy, s_mem_timeout;
    logic [SW-1:0] s_stall_cnt, s_flush_cnt;

    hazard_ctrl #(.WIDTH(32), .MAX_WAIT(MAXW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .regwriteE(regwriteE), .resultsrcE(resultsrcE), .pcsrcE(pcsrcE),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .forwardAE(forwardAE), .forwardBE(forwardBE),
        .mem_busy(mem_busy), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter instance so counter saturation is reached quickly.
    hazard_ctrl #(.WIDTH(32), .MAX_WAIT(MAXW), .CNT_W(SW)) dut_s (
        .clk(clk), .rst_n(rst_n), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .regwriteE(regwriteE), .resultsrcE(resultsrcE), .pcsrcE(pcsrcE),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .stallF(s_stallF), .stallD(s_stallD), .stallE(s_stallE), .stallM(s_stallM),
        .flushD(s_flushD), .flushE(s_flushE), .forwardAE(s_forwardAE), .forwardBE(s_forwardBE),
        .mem_busy(s_mem_busy), .mem_timeout(s_mem_timeout),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct packed {
        logic [5:0]  ctrl;   // {stallF, stallD, stallE, stallM, flushD, flushE}
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        busy;
        logic        tout;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [3:0]  ssc;
        logic [3:0]  sfc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: retired destinations as a two-entry history
    // (index 0 = Memory, 1 = Writeback), length of the current memory wait,
    // sticky timeout and plain integer counters.
    int m_we[2];
    int m_rd[2];
    int run;
    bit tout;
    int sc, fc, ssc, sfc;

    function automatic logic [1:0] fwd(input int rs);
        if (m_we[0] != 0 && m_rd[0] != 0 && m_rd[0] == rs) return 2'b10;
        if (m_we[1] != 0 && m_rd[1] != 0 && m_rd[1] == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v < maxv) ? v + 1 : maxv;
    endfunction

    task automatic model_reset();
        m_we[0] = 0; m_we[1] = 0; m_rd[0] = 0; m_rd[1] = 0;
        run = 0; tout = 1'b0;
        sc = 0; fc = 0; ssc = 0; sfc = 0;
    endtask

    // Build the expected response for the inputs currently applied.
    function automatic exp_t expect_now();
        exp_t e;
        bit ms, ld, rd, sF, fE, fD;
        ms = mem_req && !mem_ready;
        rd = (pcsrcE != 0);
        ld = (resultsrcE == 2'b01) && (rdE != 0) && (rdE == rs1D || rdE == rs2D);
        sF = ms || (!rd && ld);
        fD = !ms && rd;
        fE = !ms && (rd || ld);
        e.ctrl = {sF, sF, ms, ms, fD, fE};
        e.fa   = fwd(int'(rs1E));
        e.fb   = fwd(int'(rs2E));
        e.busy = (run > 0);
        e.tout = tout;
        e.sc   = 16'(sc);
        e.fc   = 16'(fc);
        e.ssc  = 4'(ssc);
        e.sfc  = 4'(sfc);
        return e;
    endfunction

    // Queue the expectation, clock once and advance the model.
    task automatic step();
        exp_t e;
        bit ms;
        e = expect_now();
        q.push_back(e);
        ms = mem_req && !mem_ready;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (run == int'(MAXW)) tout = 1'b1;
            if (!ms) begin
                m_we[1] = m_we[0]; m_rd[1] = m_rd[0];
                m_we[0] = int'(regwriteE); m_rd[0] = int'(rdE);
            end
            run = ms ? sat_inc(run, 255) : 0;
            if (e.ctrl[5]) begin sc = sat_inc(sc, SAT_BIG); ssc = sat_inc(ssc, SAT_SMALL); end
            if (e.ctrl[0]) begin fc = sat_inc(fc, SAT_BIG); sfc = sat_inc(sfc, SAT_SMALL); end
        end
        #1;
    endtask

    task automatic idle_inputs();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0;
        regwriteE = 0; resultsrcE = 0; pcsrcE = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ctrl",      16'({stallF, stallD, stallE, stallM, flushD, flushE}), 16'(e.ctrl));
                chk("forwardAE", 16'(forwardAE), 16'(e.fa));
                chk("forwardBE", 16'(forwardBE), 16'(e.fb));
                chk("mem_busy",  16'(mem_busy), 16'(e.busy));
                chk("mem_timeout", 16'(mem_timeout), 16'(e.tout));
                chk("stall_cnt", stall_cnt, e.sc);
                chk("flush_cnt", flush_cnt, e.fc);
                chk("s_ctrl",    16'({s_stallF, s_stallD, s_stallE, s_stallM, s_flushD, s_flushE}), 16'(e.ctrl));
                chk("s_fwd",     16'({s_forwardAE, s_forwardBE}), 16'({e.fa, e.fb}));
                chk("s_status",  16'({s_mem_busy, s_mem_timeout}), 16'({e.busy, e.tout}));
                chk("s_stall_cnt", 16'(s_stall_cnt), 16'(e.ssc));
                chk("s_flush_cnt", 16'(s_flush_cnt), 16'(e.sfc));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        bit stalling;
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        #1;

        // Reset held for two cycles with idle inputs.
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Load-use hazard, then the same with rdE = 0.
        resultsrcE = 2'b01; rdE = 5; rs1D = 5; regwriteE = 1;
        step();
        resultsrcE = 2'b00; rdE = 0; rs1D = 0; regwriteE = 0;
        step();
        resultsrcE = 2'b01; rdE = 0; rs1D = 0; rs2D = 0;
        step();
        idle_inputs();

        // Forwarding from Memory, then Writeback, then same rd in both.
        regwriteE = 1; rdE = 7;
        step();
        regwriteE = 0; rdE = 0; rs1E = 7;
        step();
        step();
        regwriteE = 1; rdE = 9; rs1E = 0;
        step();
        rdE = 9; rs2E = 9;
        step();
        regwriteE = 0; rdE = 0;
        step();
        idle_inputs();

        // Redirect together with a load-use hazard.
        resultsrcE = 2'b01; rdE = 3; rs2D = 3; pcsrcE = 2'b01;
        step();
        idle_inputs();
        step();

        // Three-cycle memory wait with shadow registers holding.
        regwriteE = 1; rdE = 4;
        step();
        mem_req = 1; mem_ready = 0; rdE = 6; rs1E = 4;
        repeat (3) step();
        mem_ready = 1;
        step();
        idle_inputs();
        repeat (2) step();

        // Timeout: six wait cycles, release, then clear only via reset.
        mem_req = 1; mem_ready = 0;
        repeat (6) step();
        mem_ready = 1;
        step();
        idle_inputs();
        repeat (2) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Randomized traffic over a small register window for frequent hits.
        stalling = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            rst_n      = ($urandom_range(0, 149) != 0);
            rs1D       = 5'($urandom_range(0, 3));
            rs2D       = 5'($urandom_range(0, 3));
            rs1E       = 5'($urandom_range(0, 3));
            rs2E       = 5'($urandom_range(0, 3));
            rdE        = 5'($urandom_range(0, 3));
            regwriteE  = 1'($urandom_range(0, 1));
            resultsrcE = 2'($urandom_range(0, 3));
            pcsrcE     = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            mem_req    = stalling ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
            mem_ready  = ($urandom_range(0, 9) < 3);
            stalling   = mem_req && !mem_ready;
            step();
        end

        idle_inputs();
        repeat (2) @(negedge clk);
        chk("queue_drained", 16'(q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
